ring_counter_gen: RTL and testbench
===================================

Name: ring_counter_gen

Overview:
- Parametrised successor to the 4-bit ring counter. Generalises width and adds Johnson mode, shift direction, enable, parallel load, legality detection, optional self-correction and a wrap pulse.
- Used as a one-hot/Johnson sequencer for phase and strobe generation.
- Fully synchronous, one clock domain.

Parameters:
- WIDTH, 4, state width in bits; legal range WIDTH >= 2.
- SEED_POS, 0, bit index of the ring-mode home state (home = 1 << SEED_POS); legal range 0..WIDTH-1.
- SELF_CORRECT, 1, 1 = an illegal state is replaced by the home state on the next enabled step; 0 = the illegal state is shifted as-is.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  step enable.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded on load.
- mode  input  1  0 = RING, 1 = JOHNSON; sampled every cycle.
- dir  input  1  0 = RIGHT (q[0] feeds q[WIDTH-1]), 1 = LEFT (q[WIDTH-1] feeds q[0]).
- q  output  WIDTH  counter state (registered).
- wrap  output  1  one-cycle pulse: the last step reached the home state.
- illegal  output  1  combinational: q is not a legal state for the current mode.

Behaviour:
- Reset: the cycle after a clk edge with rst=1, q=0 and wrap=0. rst overrides load and en.
- Home state:
  - RING: 1 << SEED_POS.
  - JOHNSON: all-zero.
- Legal states:
  - RING: popcount(q) == 1.
  - JOHNSON: q is the form 1..10..0 or 0..01..1, including all-0 and all-1 (2*WIDTH states).
- Consequence: after reset, RING mode reports illegal=1 until a load or a self-corrected step.
- Priority per edge: rst > load > en > hold.
- load=1:
  - q <= load_val; no validity check.
  - wrap <= 0.
  - en is ignored that cycle.
- en=1, load=0, illegal=1, SELF_CORRECT=1: q <= home state for the current mode; wrap <= 0.
- en=1, load=0, otherwise, RING:
  - RIGHT: q <= {q[0], q[WIDTH-1:1]}.
  - LEFT: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- en=1, load=0, otherwise, JOHNSON:
  - RIGHT: q <= {~q[0], q[WIDTH-1:1]}.
  - LEFT: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
- wrap is registered:
  - wrap <= 1 only on a normal step (not load, not correction) where the pre-step q was legal, the pre-step q was not home, and the next q equals home.
  - wrap is 0 in all other cycles.
- Latency: a step is visible on q one cycle after the en edge. wrap aligns with the q that equals home.
- Hold: en=0, load=0 → q and wrap stable, except wrap falls to 0 after one cycle.
- mode or dir change mid-sequence: takes effect on the same edge. If the current q is illegal for the new mode, illegal rises immediately (combinational) and the next enabled step applies the SELF_CORRECT rule.
- Simultaneous load and en: load wins; no step that cycle.
- rst mid-sequence: q=0 on the next cycle regardless of mode, load or en.

Decomposition:
- Package ring_counter_pkg:
  - mode_e {RING, JOHNSON} and dir_e {RIGHT, LEFT} typedefs.
  - Function is_legal(q, mode).
  - Function home_state(mode, SEED_POS).
  - Function next_state(q, mode, dir).
- One natural sub-module, ring_state_check: combinational legality and home-state compare, shared by the illegal output and the wrap/correction logic.
- Top level holds the state register and priority mux.

Test Plan (WIDTH=4, SEED_POS=0, SELF_CORRECT=1 unless stated):
- Reset, then RING with en=1, no load: q=0000 and illegal=1; next step gives q=0001, wrap=0. Further steps give 1000, 0100, 0010, 0001, with wrap=1 only when q returns to 0001.
- load_val=0100, dir=LEFT, RING, en=1: 0100 → 1000 → 0001 (wrap=1) → 0010. Mid-run, load with load_val=0110: illegal=1 immediately; next step gives q=0001 and wrap=0.
- JOHNSON, dir=RIGHT, from reset: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap=1 on the 8th step only; illegal=0 throughout.
- SELF_CORRECT=0, RING, load_val=0110, dir=RIGHT: q=0011, then 1001; illegal stays 1; wrap never asserts.
- Simultaneous load=1 and en=1 with load_val=0010: q=0010 and no step. Next: en=0 for 3 cycles holds q=0010.
- rst asserted mid-JOHNSON at q=1110: q=0000 and wrap=0 on the next cycle. rst together with load=1: q=0000, not load_val.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared types and helpers for the ring/Johnson counter.
// Helpers work on a MAXW-wide vector plus a live width argument.
package ring_counter_pkg;

  typedef enum logic {
    RING    = 1'b0,
    JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_e;

  localparam int MAXW = 64;

  typedef logic [MAXW-1:0] vec_t;

  // Johnson states are exactly the patterns with at most one
  // boundary between adjacent differing bits.
  function automatic logic is_legal(
    input vec_t  q,
    input mode_e m,
    input int    w
  );
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w && q[i]) ones++;
    end
    for (int i = 0; i < MAXW - 1; i++) begin
      if (i < w - 1 && q[i] != q[i+1]) edges++;
    end
    if (m == RING) return ones == 1;
    return edges <= 1;
  endfunction

  function automatic vec_t home_state(
    input mode_e m,
    input int    seed
  );
    vec_t h;
    h = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (m == RING && i == seed) h[i] = 1'b1;
    end
    return h;
  endfunction

  function automatic vec_t next_state(
    input vec_t  q,
    input mode_e m,
    input dir_e  d,
    input int    w
  );
    vec_t n;
    logic top;
    logic fb;
    n   = '0;
    top = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (i == w - 1) top = q[i];
    end
    if (d == RIGHT) begin
      fb = q[0] ^ (m == JOHNSON);
      for (int i = 0; i < MAXW - 1; i++) begin
        if (i < w - 1) n[i] = q[i+1];
      end
      for (int i = 0; i < MAXW; i++) begin
        if (i == w - 1) n[i] = fb;
      end
    end else begin
      fb = top ^ (m == JOHNSON);
      n[0] = fb;
      for (int i = 1; i < MAXW; i++) begin
        if (i < w) n[i] = q[i-1];
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Legality and home-state compare for the current counter value.
// Ports: q/mode in; legal, at_home, home out.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SEED_POS = 0
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  output logic             legal,
  output logic             at_home,
  output logic [WIDTH-1:0] home
);

  vec_t qx;

  always_comb begin
    qx = '0;
    qx[WIDTH-1:0] = q;
  end

  assign home    = WIDTH'(home_state(mode, SEED_POS));
  assign legal   = is_legal(qx, mode, WIDTH);
  assign at_home = (q == home);

endmodule

// File: rtl/ring_counter_gen.sv
// Parametrised ring/Johnson sequencer with load and self-correction.
// Ports: clk, rst, en, load, load_val, mode, dir -> q, wrap, illegal.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int SEED_POS     = 0,
  parameter int SELF_CORRECT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  mode_e            m;
  dir_e             d;
  vec_t             qx;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] q_d;
  logic             legal;
  logic             at_home;
  logic             wrap_d;

  assign m = mode_e'(mode);
  assign d = dir_e'(dir);

  always_comb begin
    qx = '0;
    qx[WIDTH-1:0] = q;
  end

  assign step = WIDTH'(next_state(qx, m, d, WIDTH));

  ring_state_check #(
    .WIDTH    (WIDTH),
    .SEED_POS (SEED_POS)
  ) u_check (
    .q       (q),
    .mode    (m),
    .legal   (legal),
    .at_home (at_home),
    .home    (home)
  );

  assign illegal = ~legal;

  always_comb begin
    q_d    = q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (illegal && SELF_CORRECT != 0) begin
        q_d = home;
      end else begin
        q_d = step;
        // wrap marks arrival at home from a legal, non-home state
        wrap_d = legal && !at_home && (step == home);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Scoreboard bench for ring_counter_gen (WIDTH=4, SEED_POS=0).
// Drives both a self-correcting and a non-correcting instance.
module tb_ring_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;

  logic [3:0] q_sc;
  logic       wrap_sc;
  logic       ill_sc;
  logic [3:0] q_nc;
  logic       wrap_nc;
  logic       ill_nc;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         nc;
    logic [3:0] q;
    logic       wrap;
    logic       ill;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ring_counter_gen #(
    .WIDTH        (4),
    .SEED_POS     (0),
    .SELF_CORRECT (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .dir      (dir),
    .q        (q_sc),
    .wrap     (wrap_sc),
    .illegal  (ill_sc)
  );

  ring_counter_gen #(
    .WIDTH        (4),
    .SEED_POS     (0),
    .SELF_CORRECT (0)
  ) dut_nc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .dir      (dir),
    .q        (q_nc),
    .wrap     (wrap_nc),
    .illegal  (ill_nc)
  );

  task automatic chk(
    input string      nm,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // monitor: one result per clock, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.nc) begin
          chk({e.name, " q"}, q_nc, e.q);
          chk({e.name, " wrap"}, {3'b0, wrap_nc}, {3'b0, e.wrap});
          chk({e.name, " illegal"}, {3'b0, ill_nc}, {3'b0, e.ill});
        end else begin
          chk({e.name, " q"}, q_sc, e.q);
          chk({e.name, " wrap"}, {3'b0, wrap_sc}, {3'b0, e.wrap});
          chk({e.name, " illegal"}, {3'b0, ill_sc}, {3'b0, e.ill});
        end
      end
    end
  end

  // drive one cycle of stimulus and queue the post-edge expectation
  task automatic drv(
    input logic       r,
    input logic       l,
    input logic       e,
    input logic       md,
    input logic       dr,
    input logic [3:0] lv,
    input bit         nc,
    input logic [3:0] eq,
    input logic       ew,
    input logic       ei,
    input string      nm
  );
    exp_t x;
    @(negedge clk);
    rst      = r;
    load     = l;
    en       = e;
    mode     = md;
    dir      = dr;
    load_val = lv;
    x.nc   = nc;
    x.q    = eq;
    x.wrap = ew;
    x.ill  = ei;
    x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    int budget;

    // ring right from reset: correction then rotation
    drv(1, 0, 0, 0, 0, 4'h0, 0, 4'b0000, 0, 1, "rst_ring");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b0001, 0, 0, "ring_fix");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b1000, 0, 0, "ring_r1");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b0100, 0, 0, "ring_r2");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b0010, 0, 0, "ring_r3");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b0001, 1, 0, "ring_wrap");
    drv(0, 0, 1, 0, 0, 4'h0, 0, 4'b1000, 0, 0, "ring_r5");

    // ring left after load; load beats en
    drv(0, 1, 1, 0, 1, 4'b0100, 0, 4'b0100, 0, 0, "ld_0100");
    drv(0, 0, 1, 0, 1, 4'h0, 0, 4'b1000, 0, 0, "left1");
    drv(0, 0, 1, 0, 1, 4'h0, 0, 4'b0001, 1, 0, "left_wrap");
    drv(0, 0, 1, 0, 1, 4'h0, 0, 4'b0010, 0, 0, "left3");
    drv(0, 1, 0, 0, 1, 4'b0110, 0, 4'b0110, 0, 1, "ld_bad");
    drv(0, 0, 1, 0, 1, 4'h0, 0, 4'b0001, 0, 0, "bad_fix");

    // johnson right from reset
    drv(1, 0, 0, 1, 0, 4'h0, 0, 4'b0000, 0, 0, "rst_j");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1000, 0, 0, "j1");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1100, 0, 0, "j2");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1110, 0, 0, "j3");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1111, 0, 0, "j4");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b0111, 0, 0, "j5");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b0011, 0, 0, "j6");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b0001, 0, 0, "j7");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b0000, 1, 0, "j_wrap");
    drv(0, 0, 0, 1, 0, 4'h0, 0, 4'b0000, 0, 0, "j_hold");

    // no self-correction: illegal pattern just rotates
    drv(0, 1, 0, 0, 0, 4'b0110, 1, 4'b0110, 0, 1, "nc_ld");
    drv(0, 0, 1, 0, 0, 4'h0, 1, 4'b0011, 0, 1, "nc_s1");
    drv(0, 0, 1, 0, 0, 4'h0, 1, 4'b1001, 0, 1, "nc_s2");

    // load with en, then hold
    drv(0, 1, 1, 0, 0, 4'b0010, 0, 4'b0010, 0, 0, "ld_en");
    drv(0, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 0, "hold1");
    drv(0, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 0, "hold2");
    drv(0, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 0, "hold3");

    // mode switch makes 0010 illegal for johnson
    drv(0, 0, 0, 1, 0, 4'h0, 0, 4'b0010, 0, 1, "sw_mode");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b0000, 0, 0, "sw_fix");

    // reset mid-johnson and reset over load
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1000, 0, 0, "m1");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1100, 0, 0, "m2");
    drv(0, 0, 1, 1, 0, 4'h0, 0, 4'b1110, 0, 0, "m3");
    drv(1, 0, 1, 1, 0, 4'h0, 0, 4'b0000, 0, 0, "rst_mid");
    drv(1, 1, 1, 1, 0, 4'b1010, 0, 4'b0000, 0, 0, "rst_ld");

    @(negedge clk);
    rst  = 0;
    load = 0;
    en   = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: left %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
